if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter N_BITS, default 32: width of PC, PC+4 and instruction words.
REQ-002 Parameter HALT_CODE, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
REQ-003 Parameter NOP_CODE, default 32'h0000_0000: instruction presented while the buffer is empty.
REQ-004 Clock and reset SHALL be a single clock plus an asynchronous, active-low reset, named i_clock and i_reset.
REQ-005 i_clock  in  1  rising-edge clock.
REQ-006 i_reset  in  1  asynchronous active-low reset.
REQ-007 i_valid  in  1  fetch offers an entry this cycle.
REQ-008 i_pc  in  N_BITS  PC of the offered instruction (program_counter output).
REQ-009 i_pc_plus4  in  N_BITS  PC+4 from the fetch adder.
REQ-010 i_instruction  in  N_BITS  instruction-memory word for i_pc.
REQ-011 o_ready  out  1  buffer accepts an entry; drives PC enable upstream.
REQ-012 i_ready  in  1  decode consumes the head entry this cycle (stall when low).
REQ-013 i_flush  in  1  branch/jump resolved taken; discard all buffered entries.
REQ-014 o_valid  out  1  head entry valid.
REQ-015 o_pc, o_pc_plus4, o_instruction  out  N_BITS each  head entry fields.
REQ-016 o_halted  out  1  HALT delivered to decode; fetch permanently stopped.

Function
REQ-017 The block SHALL be a 2-entry in-order FIFO with an occupancy count of 0..2; the head entry drives the outputs directly from registers.
REQ-018 push = i_valid & o_ready; pop = o_valid & i_ready.
REQ-019 o_ready = (count != 2) & (state == RUN). It SHALL depend only on registered state, with no combinational path from i_ready, i_valid or i_flush.
REQ-020 o_valid = (count != 0).
REQ-021 With count 0, o_instruction = NOP_CODE, and o_pc and o_pc_plus4 hold their last values.
REQ-022 Latency: an entry pushed into an empty buffer SHALL appear on the outputs with o_valid high on the next rising edge.
REQ-023 Push and pop in the same cycle at count 1: count stays 1, and the pushed entry becomes the head on the next edge.
REQ-024 At count 2 no push occurs because o_ready is low; a pop lowers count to 1 and raises o_ready on the next cycle.
REQ-025 The state machine SHALL have three states: RUN, HALT_PEND, DONE.
- RUN to HALT_PEND: on a push with i_instruction == HALT_CODE.
- HALT_PEND to DONE: on a pop whose head is HALT_CODE.
- DONE is terminal until reset.
REQ-026 In HALT_PEND and DONE, o_ready SHALL be 0; o_halted = (state == DONE).
REQ-027 i_flush SHALL have the highest priority: count goes to 0 on the next edge, and any push or pop in the same cycle is discarded (no halt transition from a discarded push).
REQ-028 i_flush in HALT_PEND SHALL return the state to RUN, because the HALT was speculative.
REQ-029 i_flush in DONE SHALL be ignored except for clearing count.
REQ-030 PC fields SHALL be stored unmodified; no arithmetic is performed in the block.

Reset
REQ-031 While i_reset is low, regardless of the clock: count = 0, state = RUN, o_valid = 0, o_ready = 0, o_halted = 0, o_pc = 0, o_pc_plus4 = 0, o_instruction = NOP_CODE.
REQ-032 o_ready SHALL rise on the first rising edge after i_reset deasserts; reset asserted mid-operation discards all entries immediately.

Verification
REQ-033 Streaming: i_ready = 1, push PC 0, 4, 8 with instructions 0x11, 0x22, 0x33 on consecutive cycles -> outputs show the same sequence one cycle later, count never exceeds 1, and o_ready stays 1.
REQ-034 Stall: i_ready = 0, push PC 0 and 4 -> count = 2 and o_ready = 0; raise i_ready -> PC 0, then PC 4 delivered; o_ready returns to 1 after the first pop.
REQ-035 Flush: buffer holding PC 8 and 12, assert i_flush with i_valid = 1 for PC 16 -> next cycle o_valid = 0, o_instruction = 0x0, and PC 16 is not stored.
REQ-036 Halt: push 0xFFFF_FFFF at PC 20 -> o_ready drops the next cycle; pop it -> o_halted = 1, and further i_valid is ignored.
REQ-037 Speculative halt: HALT pushed, then i_flush before it is popped -> state RUN, o_ready = 1, o_halted = 0.
REQ-038 Reset: assert i_reset low mid-stall with count = 2, asynchronously -> o_valid = 0 and o_ready = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a 2-entry in-order FIFO between fetch and decode.
// The head entry drives the outputs straight from registers. A HALT word stops
// fetch once decode has consumed it. A flush discards all buffered entries and
// cancels a HALT that has not been consumed yet.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RUN       | normal fetch; entries accepted while there is room
// HALT_PEND | HALT is buffered but not yet consumed; fetch is blocked
// DONE      | HALT has been delivered to decode; fetch stays stopped until reset
module if_id_buffer #(
  parameter int                N_BITS    = 32,
  parameter logic [N_BITS-1:0] HALT_CODE = 32'hFFFF_FFFF,
  parameter logic [N_BITS-1:0] NOP_CODE  = 32'h0000_0000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [N_BITS-1:0] i_pc,
  input  logic [N_BITS-1:0] i_pc_plus4,
  input  logic [N_BITS-1:0] i_instruction,
  output logic              o_ready,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [N_BITS-1:0] o_pc,
  output logic [N_BITS-1:0] o_pc_plus4,
  output logic [N_BITS-1:0] o_instruction,
  output logic              o_halted
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        count_q;
  logic              started_q;
  logic [N_BITS-1:0] tail_pc_q;
  logic [N_BITS-1:0] tail_pc_plus4_q;
  logic [N_BITS-1:0] tail_instruction_q;
  logic              push;
  logic              pop;

  // o_ready comes only from registers so upstream PC enable has no
  // combinational path through i_ready/i_valid/i_flush. started_q holds it
  // low until the first edge after reset.
  assign o_ready  = started_q & (count_q != 2'd2) & (state_q == RUN);
  assign o_valid  = (count_q != 2'd0);
  assign o_halted = (state_q == DONE);
  assign push     = i_valid & o_ready;
  assign pop      = o_valid & i_ready;

  // Marks the first clock edge after reset release.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A flush discards the push or pop of the same cycle, so a HALT
  // carried by a flushed push never moves the machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!i_flush && push && (i_instruction == HALT_CODE)) begin
          state_d = HALT_PEND;
        end
      end
      HALT_PEND: begin
        if (i_flush) begin
          state_d = RUN;
        end else if (pop && (o_instruction == HALT_CODE)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // FIFO storage. The head registers are the outputs. When the buffer empties,
  // the instruction shows NOP and the PC fields keep their last values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q            <= 2'd0;
      o_pc               <= '0;
      o_pc_plus4         <= '0;
      o_instruction      <= NOP_CODE;
      tail_pc_q          <= '0;
      tail_pc_plus4_q    <= '0;
      tail_instruction_q <= NOP_CODE;
    end else if (i_flush) begin
      count_q       <= 2'd0;
      o_instruction <= NOP_CODE;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            o_pc          <= i_pc;
            o_pc_plus4    <= i_pc_plus4;
            o_instruction <= i_instruction;
            count_q       <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            o_pc          <= i_pc;
            o_pc_plus4    <= i_pc_plus4;
            o_instruction <= i_instruction;
          end else if (pop) begin
            o_instruction <= NOP_CODE;
            count_q       <= 2'd0;
          end else if (push) begin
            tail_pc_q          <= i_pc;
            tail_pc_plus4_q    <= i_pc_plus4;
            tail_instruction_q <= i_instruction;
            count_q            <= 2'd2;
          end
        end
        2'd2: begin
          // Full: o_ready is low, so only a pop can happen here.
          if (pop) begin
            o_pc          <= tail_pc_q;
            o_pc_plus4    <= tail_pc_plus4_q;
            o_instruction <= tail_instruction_q;
            count_q       <= 2'd1;
          end
        end
        default: begin
          count_q <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer. Inputs change 1 ns after the rising edge,
// and outputs are checked at that same point, so each check sees the result
// of the preceding edge.
module tb_if_id_buffer;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_pc_plus4;
  logic [31:0] i_instruction;
  logic        o_ready;
  logic        i_ready;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic [31:0] o_instruction;
  logic        o_halted;

  int checks   = 0;
  int failures = 0;

  if_id_buffer dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_pc          (i_pc),
    .i_pc_plus4    (i_pc_plus4),
    .i_instruction (i_instruction),
    .o_ready       (o_ready),
    .i_ready       (i_ready),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_instruction (o_instruction),
    .o_halted      (o_halted)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    i_valid       = v;
    i_pc          = pc;
    i_pc_plus4    = pc + 32'd4;
    i_instruction = instr;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    i_ready = 1'b0;
    i_flush = 1'b0;
    #3;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got %b want 0", o_ready); end
    checks++; if (o_halted !== 1'b0) begin failures++; $display("FAIL rst_halted got %b want 0", o_halted); end
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got %h want 0", o_pc); end
    checks++; if (o_pc_plus4 !== 32'h0) begin failures++; $display("FAIL rst_pc4 got %h want 0", o_pc_plus4); end
    checks++; if (o_instruction !== 32'h0) begin failures++; $display("FAIL rst_instr got %h want 0", o_instruction); end
    tick();
    tick();
    i_reset = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_before_edge got %b want 0", o_ready); end
    tick();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_first_edge got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid_first_edge got %b want 0", o_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs = '{32'h0, 32'h4, 32'h8};
    ins = '{32'h11, 32'h22, 32'h33};
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, pcs[k], ins[k]);
      tick();
      checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got %b want 1", k, o_valid); end
      checks++; if (o_pc !== pcs[k]) begin failures++; $display("FAIL stream_pc[%0d] got %h want %h", k, o_pc, pcs[k]); end
      checks++; if (o_pc_plus4 !== pcs[k] + 32'd4) begin failures++; $display("FAIL stream_pc4[%0d] got %h want %h", k, o_pc_plus4, pcs[k] + 32'd4); end
      checks++; if (o_instruction !== ins[k]) begin failures++; $display("FAIL stream_instr[%0d] got %h want %h", k, o_instruction, ins[k]); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got %b want 1", k, o_ready); end
    end
    offer(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_drain_valid got %b want 0", o_valid); end
    checks++; if (o_instruction !== 32'h0) begin failures++; $display("FAIL stream_drain_nop got %h want 0", o_instruction); end
    checks++; if (o_pc !== 32'h8) begin failures++; $display("FAIL stream_drain_pc_hold got %h want 8", o_pc); end
  endtask

  task automatic test_stall();
    i_ready = 1'b0;
    offer(1'b1, 32'h0, 32'hA0);
    tick();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_c1 got %b want 1", o_ready); end
    offer(1'b1, 32'h4, 32'hA4);
    tick();
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_full got %b want 0", o_ready); end
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL stall_head_pc got %h want 0", o_pc); end
    offer(1'b1, 32'h8, 32'hA8);
    tick();
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL stall_hold_pc got %h want 0", o_pc); end
    offer(1'b0, 32'h0, 32'h0);
    i_ready = 1'b1;
    tick();
    checks++; if (o_pc !== 32'h4) begin failures++; $display("FAIL stall_pop1_pc got %h want 4", o_pc); end
    checks++; if (o_instruction !== 32'hA4) begin failures++; $display("FAIL stall_pop1_instr got %h want a4", o_instruction); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_after_pop got %b want 1", o_ready); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got %b want 0", o_valid); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    offer(1'b1, 32'h8, 32'hB8);
    tick();
    offer(1'b1, 32'hC, 32'hBC);
    tick();
    offer(1'b1, 32'h10, 32'hC0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %b want 0", o_valid); end
    checks++; if (o_instruction !== 32'h0) begin failures++; $display("FAIL flush_instr got %h want 0", o_instruction); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got %b want 1", o_ready); end
    offer(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_no_store got %b want 0", o_valid); end
    // flush beats a same-cycle push and pop at count 1
    offer(1'b1, 32'h28, 32'hD0);
    i_ready = 1'b1;
    tick();
    offer(1'b1, 32'h2C, 32'hD4);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_prio_valid got %b want 0", o_valid); end
    checks++; if (o_pc !== 32'h28) begin failures++; $display("FAIL flush_prio_pc got %h want 28", o_pc); end
  endtask

  task automatic test_spec_halt();
    // halt carried by a flushed push must not block fetch
    i_ready = 1'b0;
    offer(1'b1, 32'h14, 32'hFFFF_FFFF);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL spec_flushed_push_ready got %b want 1", o_ready); end
    offer(1'b1, 32'h14, 32'hFFFF_FFFF);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL spec_halt_ready got %b want 0", o_ready); end
    checks++; if (o_instruction !== 32'hFFFF_FFFF) begin failures++; $display("FAIL spec_halt_head got %h want ffffffff", o_instruction); end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL spec_ready got %b want 1", o_ready); end
    checks++; if (o_halted !== 1'b0) begin failures++; $display("FAIL spec_halted got %b want 0", o_halted); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL spec_valid got %b want 0", o_valid); end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    offer(1'b1, 32'h30, 32'hE0);
    tick();
    offer(1'b1, 32'h34, 32'hE4);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rmid_full got %b want 0", o_ready); end
    #2;
    i_reset = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got %b want 0", o_ready); end
    checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL rmid_pc got %h want 0", o_pc); end
    tick();
    i_reset = 1'b1;
    tick();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready_after got %b want 1", o_ready); end
  endtask

  task automatic test_halt();
    i_ready = 1'b0;
    offer(1'b1, 32'h14, 32'hFFFF_FFFF);
    tick();
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL halt_ready_drop got %b want 0", o_ready); end
    checks++; if (o_halted !== 1'b0) begin failures++; $display("FAIL halt_early got %b want 0", o_halted); end
    offer(1'b1, 32'h18, 32'h55);
    i_ready = 1'b1;
    tick();
    checks++; if (o_halted !== 1'b1) begin failures++; $display("FAIL halt_done got %b want 1", o_halted); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL halt_ready got %b want 0", o_ready); end
    tick();
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL halt_ignore_valid got %b want 0", o_valid); end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    checks++; if (o_halted !== 1'b1) begin failures++; $display("FAIL halt_flush_done got %b want 1", o_halted); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL halt_flush_ready got %b want 0", o_ready); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_spec_halt();
    test_reset_mid();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
